// File: rtl/mac_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
//   Shared types and helpers for the mac_accumulator block.
//   - state_t : accumulator FSM states (IDLE, ACCUM, HOLD)
//   - cnt_w() : beat-counter width for a given dot-product length
//               (CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1)
// ---------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // A length-1 dot product still needs a one-bit counter to stay legal.
  function automatic int cnt_w(input int k_len);
    return (k_len > 1) ? $clog2(k_len) : 1;
  endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// ---------------------------------------------------------------------------
// mac_accumulator_if
//   Operand-in / result-out handshake bundle for mac_accumulator.
//   Parameters: DATA_W (operand width), ACC_W (result width).
//   Signals:
//     in_valid  : operand pair present             (master -> slave)
//     in_ready  : pair accepted this cycle         (slave  -> master)
//     a_in,b_in : unsigned operands                (master -> slave)
//     out_valid : acc_out holds a finished result  (slave  -> master)
//     out_ready : downstream takes the result      (master -> slave)
//     acc_out   : dot-product result               (slave  -> master)
//     ovf       : sticky carry-out flag for result (slave  -> master)
//   Modports: master (operand fetch / result collector side), slave (MAC).
// ---------------------------------------------------------------------------
interface mac_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;

  modport master (
    output in_valid,
    output a_in,
    output b_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  acc_out,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  a_in,
    input  b_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output acc_out,
    output ovf
  );

endinterface

// File: rtl/mac_accumulator_rca_adder.sv
// ---------------------------------------------------------------------------
// fulladder / rca_adder
//   fulladder : one-bit full adder cell.
//     ports: a, b, cin (in); sum, cout (out)
//   rca_adder #(W) : W-bit ripple-carry adder, a chain of W fulladder cells,
//     bit 0 fed by cin, cout taken from the top cell.
//     ports: a[W-1:0], b[W-1:0], cin (in); sum[W-1:0], cout (out)
// ---------------------------------------------------------------------------
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

module rca_adder #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // carry[i] is the carry into bit i; carry[W] leaves the top of the chain.
  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[W];

endmodule

// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
//   Sequential multiply-accumulate element. Accepts K_LEN unsigned operand
//   pairs, sums their products through a ripple-carry adder and presents one
//   dot-product result, held until the downstream side takes it.
//
//   Parameters:
//     DATA_W : operand width (a_in, b_in), unsigned
//     ACC_W  : accumulator / result width, must be >= 2*DATA_W
//     K_LEN  : products per result, must be >= 1
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : mac_accumulator_if.slave (in_valid/in_ready/a_in/b_in,
//             out_valid/out_ready/acc_out/ovf)
//
//   Build option:
//     MAC_ACC_SATURATE_EN : when defined, a carry out of the accumulator
//       clamps it to all-ones for the rest of the result; otherwise the sum
//       wraps modulo 2^ACC_W. ovf reports the carry-out in both builds.
// ---------------------------------------------------------------------------
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int K_LEN  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mac_accumulator_if.slave   bus
);

  localparam int              CNT_W = cnt_w(K_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K_LEN - 1);

`ifdef MAC_ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    count;
  logic [ACC_W-1:0]    acc;
  logic                ovf_r;

  logic                rdy;
  logic                accept;
  logic                handoff;

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W-1:0]    sum;
  logic                cout;

  // Clamp on carry-out in the saturating build. Once the accumulator sits at
  // all-ones, any further non-zero product carries again and re-clamps, and a
  // zero product leaves it untouched, so the clamp persists for the result.
  function automatic logic [ACC_W-1:0] sat_result(input logic [ACC_W-1:0] s,
                                                  input logic             c);
    return (SAT_EN && c) ? {ACC_W{1'b1}} : s;
  endfunction

  // Handshake decode
  assign rdy     = (state != HOLD);
  assign accept  = bus.in_valid && rdy;
  assign handoff = (state == HOLD) && bus.out_ready;

  // Product and accumulate: unsigned multiply, zero-extended into the adder
  assign prod     = {{DATA_W{1'b0}}, bus.a_in} * {{DATA_W{1'b0}}, bus.b_in};
  assign prod_ext = ACC_W'(prod);

  rca_adder #(
    .W (ACC_W)
  ) u_add (
    .a    (acc),
    .b    (prod_ext),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state. IDLE and ACCUM behave alike on an accept; the last beat
  // (count == K_LEN-1) goes straight to HOLD, which also covers K_LEN == 1.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_nx = (count == LAST) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accumulator, beat counter and sticky overflow. A handoff clears all three
  // so the next result starts from zero; bubbles leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      ovf_r <= 1'b0;
    end else if (handoff) begin
      acc   <= '0;
      count <= '0;
      ovf_r <= 1'b0;
    end else if (accept) begin
      acc   <= sat_result(sum, cout);
      count <= count + CNT_W'(1);
      ovf_r <= ovf_r | cout;
    end
  end

  // Outputs
  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state == HOLD);
  assign bus.acc_out   = acc;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_accumulator
//   Self-checking bench for mac_accumulator. dut0 uses the default
//   parameters (DATA_W=8, ACC_W=20, K_LEN=4); dut1 uses ACC_W=16, K_LEN=2 to
//   reach the carry-out / saturation behaviour (MAC_ACC_SATURATE_EN aware).
// ---------------------------------------------------------------------------
module tb_mac_accumulator;

  localparam int DW  = 8;
  localparam int AW0 = 20;
  localparam int K0  = 4;
  localparam int AW1 = 16;
  localparam int K1  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mac_accumulator_if #(.DATA_W(DW), .ACC_W(AW0)) bus0 ();
  mac_accumulator_if #(.DATA_W(DW), .ACC_W(AW1)) bus1 ();

  mac_accumulator #(.DATA_W(DW), .ACC_W(AW0), .K_LEN(K0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  mac_accumulator #(.DATA_W(DW), .ACC_W(AW1), .K_LEN(K1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    logic [3:0][1:0] gap;     // idle cycles inserted before each beat
    logic [19:0]     exp_acc;
    logic            exp_ovf;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (w == 0) begin
      bus0.in_valid = v; bus0.a_in = a; bus0.b_in = b;
    end else begin
      bus1.in_valid = v; bus1.a_in = a; bus1.b_in = b;
    end
  endtask

  task automatic set_ordy(input int w, input logic r);
    if (w == 0) bus0.out_ready = r;
    else        bus1.out_ready = r;
  endtask

  function automatic logic get_rdy(input int w);
    return (w == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  function automatic logic get_ov(input int w);
    return (w == 0) ? bus0.out_valid : bus1.out_valid;
  endfunction

  function automatic logic get_ovf(input int w);
    return (w == 0) ? bus0.ovf : bus1.ovf;
  endfunction

  function automatic logic [31:0] get_acc(input int w);
    return (w == 0) ? 32'(bus0.acc_out) : 32'(bus1.acc_out);
  endfunction

  // Reference: the result is the plain integer sum of all products, reduced
  // to the result width either by wrapping or by clamping.
  function automatic void model(input longint total, input int aw,
                                output longint res, output logic ovf);
    longint lim;
    lim = longint'(1) << aw;
    ovf = (total >= lim);
`ifdef MAC_ACC_SATURATE_EN
    res = ovf ? lim - 1 : total;
`else
    res = total % lim;
`endif
  endfunction

  // Present one pair and hold it until accepted (bounded).
  task automatic send_beat(input int w, input logic [7:0] a, input logic [7:0] b, input string nm);
    logic r;
    int   tries;
    tries = 0;
    set_in(w, 1'b1, a, b);
    do begin
      r = get_rdy(w);
      @(posedge clk); #1;
      tries++;
    end while (!r && tries < 50);
    if (!r) check({nm, " accept timeout"}, 32'd0, 32'd1);
    set_in(w, 1'b0, 8'd0, 8'd0);
  endtask

  // Wait for a result, compare it, hand it off and check the cleared state.
  task automatic get_result(input int w, input logic [31:0] exp_acc, input logic exp_ovf, input string nm);
    int t;
    t = 0;
    while (!get_ov(w) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check({nm, " out_valid"}, 32'(get_ov(w)), 32'd1);
    check({nm, " acc_out"}, get_acc(w), exp_acc);
    check({nm, " ovf"}, 32'(get_ovf(w)), 32'(exp_ovf));
    set_ordy(w, 1'b1);
    @(posedge clk); #1;
    set_ordy(w, 1'b0);
    check({nm, " post-handoff out_valid"}, 32'(get_ov(w)), 32'd0);
    check({nm, " post-handoff in_ready"}, 32'(get_rdy(w)), 32'd1);
    check({nm, " post-handoff acc_out"}, get_acc(w), 32'd0);
  endtask

  vec_t vt[6];

  initial begin
    longint total;
    longint res;
    logic   movf;
    string  nm;

    set_in(0, 1'b0, 8'd0, 8'd0);
    set_in(1, 1'b0, 8'd0, 8'd0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);

    vt[0] = '{a: {8'd1, 8'd7, 8'd5, 8'd3}, b: {8'd2, 8'd8, 8'd6, 8'd4},
              gap: {2'd0, 2'd0, 2'd0, 2'd0}, exp_acc: 20'd100, exp_ovf: 1'b0};
    vt[1] = '{a: {8'd255, 8'd255, 8'd255, 8'd255}, b: {8'd255, 8'd255, 8'd255, 8'd255},
              gap: {2'd0, 2'd0, 2'd0, 2'd0}, exp_acc: 20'd260100, exp_ovf: 1'b0};
    vt[2] = '{a: {8'd1, 8'd7, 8'd5, 8'd3}, b: {8'd2, 8'd8, 8'd6, 8'd4},
              gap: {2'd3, 2'd2, 2'd1, 2'd0}, exp_acc: 20'd100, exp_ovf: 1'b0};
    vt[3] = '{a: {8'd1, 8'd20, 8'd0, 8'd10}, b: {8'd1, 8'd5, 8'd0, 8'd10},
              gap: {2'd1, 2'd1, 2'd1, 2'd1}, exp_acc: 20'd201, exp_ovf: 1'b0};
    vt[4] = '{a: {8'd0, 8'd0, 8'd0, 8'd0}, b: {8'd0, 8'd0, 8'd0, 8'd0},
              gap: {2'd0, 2'd2, 2'd0, 2'd0}, exp_acc: 20'd0, exp_ovf: 1'b0};
    vt[5] = '{a: {8'd1, 8'd255, 8'd2, 8'd128}, b: {8'd255, 8'd1, 8'd128, 8'd2},
              gap: {2'd0, 2'd0, 2'd3, 2'd0}, exp_acc: 20'd1022, exp_ovf: 1'b0};

    // Reset state
    #12;
    check("reset out_valid", 32'(bus0.out_valid), 32'd0);
    check("reset acc_out", 32'(bus0.acc_out), 32'd0);
    check("reset ovf", 32'(bus0.ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset in_ready", 32'(bus0.in_ready), 32'd1);
    check("reset dut1 acc_out", 32'(bus1.acc_out), 32'd0);

    // Table-driven vectors on dut0
    for (int i = 0; i < 6; i++) begin
      nm = $sformatf("vec%0d", i);
      for (int j = 0; j < 4; j++) begin
        repeat (int'(vt[i].gap[j])) begin
          @(posedge clk); #1;
        end
        send_beat(0, vt[i].a[j], vt[i].b[j], nm);
      end
      check({nm, " latency"}, 32'(bus0.out_valid), 32'd1);
      get_result(0, 32'(vt[i].exp_acc), vt[i].exp_ovf, nm);
    end

    // Result held under back-pressure; extra beats are refused
    send_beat(0, 8'd3, 8'd4, "bp");
    send_beat(0, 8'd5, 8'd6, "bp");
    send_beat(0, 8'd7, 8'd8, "bp");
    send_beat(0, 8'd1, 8'd2, "bp");
    set_in(0, 1'b1, 8'd9, 8'd9);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold acc_out c%0d", c), 32'(bus0.acc_out), 32'd100);
      check($sformatf("bp hold in_ready c%0d", c), 32'(bus0.in_ready), 32'd0);
      check($sformatf("bp hold out_valid c%0d", c), 32'(bus0.out_valid), 32'd1);
    end
    set_in(0, 1'b0, 8'd0, 8'd0);
    get_result(0, 32'd100, 1'b0, "bp");
    for (int j = 0; j < 4; j++) send_beat(0, 8'd1, 8'd1, "bp next");
    get_result(0, 32'd4, 1'b0, "bp next");

    // Asynchronous reset mid-result discards the partial sum
    send_beat(0, 8'd3, 8'd4, "rst");
    send_beat(0, 8'd5, 8'd6, "rst");
    check("rst partial acc", 32'(bus0.acc_out), 32'd42);
    #3 rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(bus0.out_valid), 32'd0);
    check("rst acc_out", 32'(bus0.acc_out), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(0, 8'd3, 8'd4, "rst after");
    send_beat(0, 8'd5, 8'd6, "rst after");
    send_beat(0, 8'd7, 8'd8, "rst after");
    send_beat(0, 8'd1, 8'd2, "rst after");
    get_result(0, 32'd100, 1'b0, "rst after");

    // Carry out of a 16-bit accumulator (K_LEN=2)
    send_beat(1, 8'd255, 8'd255, "ovf16");
    check("ovf16 first beat ovf", 32'(bus1.ovf), 32'd0);
    send_beat(1, 8'd255, 8'd255, "ovf16");
`ifdef MAC_ACC_SATURATE_EN
    get_result(1, 32'd65535, 1'b1, "ovf16");
`else
    get_result(1, 32'd64514, 1'b1, "ovf16");
`endif
    send_beat(1, 8'd255, 8'd255, "fit16");
    send_beat(1, 8'd1, 8'd1, "fit16");
    get_result(1, 32'd65026, 1'b0, "fit16");

    // Randomized results on dut0 against the reference model
    for (int r = 0; r < 25; r++) begin
      logic [7:0] a;
      logic [7:0] b;
      total = 0;
      nm = $sformatf("rand0_%0d", r);
      for (int j = 0; j < K0; j++) begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        total += longint'(a) * longint'(b);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_beat(0, a, b, nm);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      model(total, AW0, res, movf);
      get_result(0, 32'(res), movf, nm);
    end

    // Randomized results on dut1, where carry-out is common
    for (int r = 0; r < 25; r++) begin
      logic [7:0] a;
      logic [7:0] b;
      total = 0;
      nm = $sformatf("rand1_%0d", r);
      for (int j = 0; j < K1; j++) begin
        a = 8'($urandom_range(100, 255));
        b = 8'($urandom_range(0, 255));
        total += longint'(a) * longint'(b);
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk); #1;
        end
        send_beat(1, a, b, nm);
      end
      model(total, AW1, res, movf);
      get_result(1, 32'(res), movf, nm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
